// File: rtl/sensores_pkg.sv
// Shared types and constants for the ultrasonic sensor scheduler: FSM encoding,
// distance saturation value and default timing figures (50 MHz clock).
package sensores_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIGGER,
    WAIT_ECHO,
    MEASURE,
    CONVERT,
    PUBLISH,
    GUARD
  } estado_t;

  localparam logic [8:0] DIST_SAT = 9'd511;

  localparam int NUM_SENSORES_DEF = 4;
  localparam int CICLOS_TRIG_DEF  = 500;
  localparam int TIMEOUT_DEF      = 500000;
  localparam int CICLOS_CM_DEF    = 2900;
  localparam int GUARDA_DEF       = 3000000;

  localparam int CNT_W = 32;

endpackage

// File: rtl/divisor_secuencial.sv
// Restoring divider by a constant: one subtraction per cycle, quotient saturates at 511.
// done is high for one cycle, quotient+1 cycles after start; no backpressure (start always accepted).
module divisor_secuencial
  import sensores_pkg::*;
#(
  parameter int DIVISOR = CICLOS_CM_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [30:0] dividendo_i,
  output logic        done_o,
  output logic [8:0]  cociente_o
);

  localparam logic [30:0] DIV = 31'(DIVISOR);

  logic [30:0] resto_q, resto_d;
  logic [8:0]  coc_q, coc_d;
  logic        activo_q, activo_d;

  always_comb begin
    resto_d  = resto_q;
    coc_d    = coc_q;
    activo_d = activo_q;
    done_o   = activo_q && ((resto_q < DIV) || (coc_q == DIST_SAT));
    if (start_i) begin
      resto_d  = dividendo_i;
      coc_d    = '0;
      activo_d = 1'b1;
    end else if (activo_q) begin
      if (done_o) begin
        activo_d = 1'b0;
      end else begin
        resto_d = resto_q - DIV;
        coc_d   = coc_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resto_q  <= '0;
      coc_q    <= '0;
      activo_q <= 1'b0;
    end else begin
      resto_q  <= resto_d;
      coc_q    <= coc_d;
      activo_q <= activo_d;
    end
  end

  assign cociente_o = coc_q;

endmodule

// File: rtl/planificador_sensores.sv
// Round-robin scheduler sharing one echo-timing engine among ultrasonic sensors; one ping at a time.
// Result held on dist_valid until dist_ready, then a crosstalk guard interval precedes the next ping.
module planificador_sensores
  import sensores_pkg::*;
#(
  parameter int NUM_SENSORES = NUM_SENSORES_DEF,
  parameter int CICLOS_TRIG  = CICLOS_TRIG_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CICLOS_CM    = CICLOS_CM_DEF,
  parameter int GUARDA       = GUARDA_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_SENSORES-1:0] mascara,
  input  logic [NUM_SENSORES-1:0] echo,
  output logic [NUM_SENSORES-1:0] trig,
  output logic                    dist_valid,
  input  logic                    dist_ready,
  output logic [1:0]              dist_sensor,
  output logic [8:0]              distancia,
  output logic                    timeout,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] TRIG_FIN  = CNT_W'(CICLOS_TRIG);
  localparam logic [CNT_W-1:0] TO_FIN    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] GUARD_FIN = CNT_W'(GUARDA);

  estado_t state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [1:0]              sel_q, sel_d;
  logic [1:0]              dsen_q, dsen_d;
  logic [8:0]              dist_q, dist_d;
  logic                    to_q, to_d;
  logic [NUM_SENSORES-1:0] echo_s1_q, echo_s2_q;
  logic                    echo_prev_q;
  logic                    echo_sel;
  logic [1:0]              prox_sel;
  logic                    hay_candidato;
  logic                    div_start, div_done;
  logic [8:0]              div_coc;
  int                      idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1_q <= '0;
      echo_s2_q <= '0;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
    end
  end

  // echo_prev_q tracks the selected line through TRIGGER, so a line already high is not an edge
  assign echo_sel = echo_s2_q[sel_q];

  always_comb begin
    prox_sel      = sel_q;
    hay_candidato = 1'b0;
    idx           = 0;
    for (int k = 1; k <= NUM_SENSORES; k++) begin
      idx = (int'(sel_q) + k) % NUM_SENSORES;
      if (!hay_candidato && mascara[idx]) begin
        hay_candidato = 1'b1;
        prox_sel      = 2'(idx);
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    dsen_d    = dsen_q;
    dist_d    = dist_q;
    to_d      = to_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && hay_candidato) begin
          sel_d   = prox_sel;
          cnt_d   = '0;
          state_d = TRIGGER;
        end
      end
      TRIGGER: begin
        if (cnt_inc >= TRIG_FIN) begin
          cnt_d   = '0;
          state_d = WAIT_ECHO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_ECHO: begin
        if (echo_sel && !echo_prev_q) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end else if (cnt_inc >= TO_FIN) begin
          dist_d  = DIST_SAT;
          to_d    = 1'b1;
          dsen_d  = sel_q;
          state_d = PUBLISH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEASURE: begin
        if (echo_sel) begin
          if (cnt_inc >= TO_FIN) begin
            dist_d  = DIST_SAT;
            to_d    = 1'b1;
            dsen_d  = sel_q;
            state_d = PUBLISH;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          div_start = 1'b1;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        if (div_done) begin
          dist_d  = div_coc;
          to_d    = 1'b0;
          dsen_d  = sel_q;
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        if (dist_ready) begin
          cnt_d   = '0;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (cnt_inc >= GUARD_FIN) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= 2'(NUM_SENSORES - 1);
      dsen_q      <= '0;
      dist_q      <= '0;
      to_q        <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      dsen_q      <= dsen_d;
      dist_q      <= dist_d;
      to_q        <= to_d;
      echo_prev_q <= echo_sel;
    end
  end

  divisor_secuencial #(
    .DIVISOR(CICLOS_CM)
  ) u_divisor (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividendo_i(cnt_q[30:0]),
    .done_o     (div_done),
    .cociente_o (div_coc)
  );

  // trig decodes straight from the state register so reset removes it without waiting for a clock
  always_comb begin
    trig = '0;
    if (state_q == TRIGGER) trig[sel_q] = 1'b1;
  end

  assign dist_valid  = (state_q == PUBLISH);
  assign busy        = (state_q != IDLE);
  assign dist_sensor = dsen_q;
  assign distancia   = dist_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_planificador_sensores.sv
// Directed bench with a result scoreboard: expected results are queued as pings are
// stimulated and checked when the DUT hands a result over.
module tb_planificador_sensores;

  localparam int N      = 4;
  localparam int TRIG   = 5;
  localparam int TO     = 20000;
  localparam int CM     = 2900;
  localparam int GUARDA = 10;

  typedef struct {
    logic [1:0] s;
    logic [8:0] d;
    logic       t;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [N-1:0] mascara;
  logic [N-1:0] echo;
  logic [N-1:0] trig;
  logic         dist_valid;
  logic         dist_ready;
  logic [1:0]   dist_sensor;
  logic [8:0]   distancia;
  logic         timeout;
  logic         busy;

  int   errors = 0;
  int   checks = 0;
  res_t sb[$];
  res_t e;

  always #5 clk = ~clk;

  planificador_sensores #(
    .NUM_SENSORES(N),
    .CICLOS_TRIG (TRIG),
    .TIMEOUT     (TO),
    .CICLOS_CM   (CM),
    .GUARDA      (GUARDA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mascara    (mascara),
    .echo       (echo),
    .trig       (trig),
    .dist_valid (dist_valid),
    .dist_ready (dist_ready),
    .dist_sensor(dist_sensor),
    .distancia  (distancia),
    .timeout    (timeout),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for trig[s]==v; n returns the number of cycles waited.
  task automatic wait_trig(input int s, input logic v, input int budget, output int n);
    logic [N-1:0] onehot;
    n = 0;
    while (trig[s] !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("trig%0d_to_%0d", s, v), 32'(trig[s]), 32'(v));
    if (v) begin
      onehot = '0;
      onehot[s] = 1'b1;
      chk($sformatf("trig%0d_onehot", s), 32'(trig), 32'(onehot));
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (dist_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 32'(dist_valid), 32'd1);
  endtask

  task automatic pulse_echo(input int s, input int w);
    echo[s] = 1'b1;
    repeat (w) @(negedge clk);
    echo[s] = 1'b0;
  endtask

  task automatic accept();
    dist_ready = 1'b1;
    @(negedge clk);
    dist_ready = 1'b0;
    chk("valid_drop", 32'(dist_valid), 32'd0);
  endtask

  task automatic push(input logic [1:0] s, input logic [8:0] d, input logic t);
    res_t r;
    r.s = s;
    r.d = d;
    r.t = t;
    sb.push_back(r);
  endtask

  // Handshake monitor: samples mid-low-phase, after the bench has driven dist_ready.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && dist_valid && dist_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 32'(dist_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res_sensor", 32'(dist_sensor), 32'(e.s));
        chk("res_dist", 32'(distancia), 32'(e.d));
        chk("res_timeout", 32'(timeout), 32'(e.t));
      end
    end
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    enable     = 1'b0;
    mascara    = '0;
    echo       = '0;
    dist_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_valid", 32'(dist_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dist", 32'(distancia), 32'd0);
    chk("rst_sensor", 32'(dist_sensor), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // Single sensor, 5800-cycle echo -> 2 cm; consumer stalls 100 cycles.
    enable  = 1'b1;
    mascara = 4'b0001;
    push(2'd0, 9'd2, 1'b0);
    wait_trig(0, 1'b1, 50, n);
    wait_trig(0, 1'b0, 50, n);
    chk("trig_width", 32'(n), 32'(TRIG));
    pulse_echo(0, 5800);
    wait_valid(100, n);
    for (int i = 0; i < 100; i++) begin
      chk("stall_hold", {19'd0, dist_valid, timeout, dist_sensor, distancia},
          {19'd0, 1'b1, 1'b0, 2'd0, 9'd2});
      chk("stall_no_trig", 32'(trig), 32'd0);
      @(negedge clk);
    end
    push(2'd0, 9'd511, 1'b1);
    accept();
    wait_trig(0, 1'b1, 100, n);
    chk("guard_gap", 32'(n), 32'(GUARDA + 1));

    // No echo on sensor 0 -> timeout result exactly TIMEOUT cycles after trig falls.
    wait_trig(0, 1'b0, 50, n);
    wait_valid(TO + 100, n);
    chk("echo_wait_timeout_latency", 32'(n), 32'(TO));
    mascara = 4'b0010;
    accept();

    // Sensor 1 echo already high before its trigger; activity on sensor 0 ignored.
    echo[1] = 1'b1;
    push(2'd1, 9'd511, 1'b1);
    wait_trig(1, 1'b1, 100, n);
    wait_trig(1, 1'b0, 50, n);
    pulse_echo(0, 50);
    wait_valid(TO + 100, n);
    chk("prehigh_timeout_latency", 32'(n), 32'(TO - 50));
    echo[1] = 1'b0;
    accept();

    // Reset during MEASURE on sensor 1.
    wait_trig(1, 1'b1, 100, n);
    wait_trig(1, 1'b0, 50, n);
    echo[1] = 1'b1;
    repeat (100) @(negedge clk);
    chk("measure_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_trig", 32'(trig), 32'd0);
    chk("async_rst_dist", 32'(distancia), 32'd0);
    echo[1] = 1'b0;
    mascara = 4'b0101;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin over sensors 0 and 2 with dist_ready tied high.
    dist_ready = 1'b1;
    push(2'd0, 9'd1, 1'b0);
    push(2'd2, 9'd3, 1'b0);
    push(2'd0, 9'd1, 1'b0);
    wait_trig(0, 1'b1, 50, n);
    wait_trig(0, 1'b0, 50, n);
    pulse_echo(0, 2900);
    wait_trig(2, 1'b1, 200, n);
    wait_trig(2, 1'b0, 50, n);
    pulse_echo(2, 8700);
    wait_trig(0, 1'b1, 200, n);
    wait_trig(0, 1'b0, 50, n);
    pulse_echo(0, 2900);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
